mult_div_sequencer: RTL and testbench

- Sequential controller that runs an N-cycle radix-2 iteration loop.
- Signed Booth multiplication: op=0.
- Unsigned non-restoring division: op=1.
- Owns the A/Q/M working registers, the iteration counter and the start/done handshake.
- Instantiates one combinational step sub-module per iteration.
- Sits between the top-level operand/command registers and the result display/bus logic of the P02 ALU.

---
 rtl/mult_div_sequencer_pkg.sv | 15 +
 rtl/mult_div_step.sv | 45 ++++
 rtl/mult_div_sequencer.sv | 165 ++++++++++++++++
 tb/tb_mult_div_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_sequencer_pkg.sv
// Shared opcode encodings and sequencer state type for the multiply/divide
// sequencer and its single-iteration step.
package mult_div_sequencer_pkg;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CALC = 3'd1,
    FIX  = 3'd2,
    DONE = 3'd3
  } seq_state_e;

endpackage

// File: rtl/mult_div_step.sv
// One radix-2 iteration: a Booth multiply step (with arithmetic shift right)
// or a non-restoring divide step (with shift left), purely combinational.
module mult_div_step
  import mult_div_sequencer_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         op_i,
  input  logic [N:0]   a_i,
  input  logic [N-1:0] q_i,
  input  logic         q1_i,
  input  logic [N:0]   m_i,
  output logic [N:0]   a_o,
  output logic [N-1:0] q_o,
  output logic         q1_o
);

  logic [N:0] sum;
  logic [N:0] shl_a;

  always_comb begin
    a_o   = a_i;
    q_o   = q_i;
    q1_o  = q1_i;
    sum   = a_i;
    shl_a = '0;
    if (op_i == OP_MUL) begin
      unique case ({q_i[0], q1_i})
        2'b10:   sum = a_i - m_i;
        2'b01:   sum = a_i + m_i;
        default: sum = a_i;
      endcase
      // Arithmetic shift right of {A,Q,Q_1}; the guard bit keeps the sign.
      a_o  = {sum[N], sum[N:1]};
      q_o  = {sum[0], q_i[N-1:1]};
      q1_o = q_i[0];
    end else begin
      shl_a = {a_i[N-1:0], q_i[N-1]};
      sum   = a_i[N] ? (shl_a + m_i) : (shl_a - m_i);
      a_o   = sum;
      q_o   = {q_i[N-2:0], ~sum[N]};
    end
  end

endmodule

// File: rtl/mult_div_sequencer.sv
// N-cycle radix-2 sequencer: signed Booth multiply (op=0) or unsigned
// non-restoring divide (op=1) with a start/ready/busy/done handshake.
module mult_div_sequencer
  import mult_div_sequencer_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         op,
  input  logic [N-1:0] data_a,
  input  logic [N-1:0] data_b,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result_hi,
  output logic [N-1:0] result_lo,
  output logic         div_by_zero
);

  localparam int unsigned CW = $clog2(N + 1);

  seq_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N:0]    a_q, a_d;
  logic [N-1:0]  q_q, q_d;
  logic          q1_q, q1_d;
  logic [N:0]    m_q, m_d;
  logic          op_q, op_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [N-1:0]  res_hi_q, res_hi_d;
  logic [N-1:0]  res_lo_q, res_lo_d;
  logic          dbz_q, dbz_d;

  logic [N:0]    step_a;
  logic [N-1:0]  step_q;
  logic          step_q1;
  logic [N:0]    a_fix;

  mult_div_step #(.N(N)) u_step (
    .op_i (op_q),
    .a_i  (a_q),
    .q_i  (q_q),
    .q1_i (q1_q),
    .m_i  (m_q),
    .a_o  (step_a),
    .q_o  (step_q),
    .q1_o (step_q1)
  );

  // Next-state, datapath load/iterate and result capture on DONE entry.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    q_d      = q_q;
    q1_d     = q1_q;
    m_d      = m_q;
    op_d     = op_q;
    done_d   = 1'b0;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    dbz_d    = dbz_q;
    a_fix    = a_q[N] ? (a_q + m_q) : a_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d  = op;
          a_d   = '0;
          q_d   = data_a;
          q1_d  = 1'b0;
          cnt_d = CW'(N);
          dbz_d = 1'b0;
          if (op == OP_DIV) begin
            m_d = {1'b0, data_b};
            if (data_b == '0) begin
              state_d  = DONE;
              res_hi_d = data_a;
              res_lo_d = '1;
              dbz_d    = 1'b1;
            end else begin
              state_d = CALC;
            end
          end else begin
            m_d     = {data_b[N-1], data_b};
            state_d = CALC;
          end
        end
      end
      CALC: begin
        a_d   = step_a;
        q_d   = step_q;
        q1_d  = step_q1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          if (op_q == OP_DIV) begin
            state_d = FIX;
          end else begin
            state_d  = DONE;
            res_hi_d = step_a[N-1:0];
            res_lo_d = step_q;
          end
        end
      end
      FIX: begin
        a_d      = a_fix;
        res_hi_d = a_fix[N-1:0];
        res_lo_d = q_q;
        state_d  = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      q_q      <= '0;
      q1_q     <= 1'b0;
      m_q      <= '0;
      op_q     <= OP_MUL;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      q_q      <= q_d;
      q1_q     <= q1_d;
      m_q      <= m_d;
      op_q     <= op_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      dbz_q    <= dbz_d;
    end
  end

  assign ready       = ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign result_hi   = res_hi_q;
  assign result_lo   = res_lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Self-checking bench for mult_div_sequencer: directed cases, randomized ops
// against an arithmetic reference model, reset abort and back-to-back starts.
module tb_mult_div_sequencer;

  localparam int unsigned NB = 4;
  localparam int BUDGET = 25;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          op;
  logic [NB-1:0] data_a;
  logic [NB-1:0] data_b;
  logic          ready;
  logic          busy;
  logic          done;
  logic [NB-1:0] result_hi;
  logic [NB-1:0] result_lo;
  logic          div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mult_div_sequencer #(.N(NB)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .data_a      (data_a),
    .data_b      (data_b),
    .ready       (ready),
    .busy        (busy),
    .done        (done),
    .result_hi   (result_hi),
    .result_lo   (result_lo),
    .div_by_zero (div_by_zero)
  );

  // Reference: plain integer arithmetic on the operands.
  task automatic model(input logic o, input logic [NB-1:0] a, input logic [NB-1:0] b,
                       output logic [NB-1:0] hi, output logic [NB-1:0] lo,
                       output logic dz, output int lat);
    int ia, ib, prod;
    logic [31:0] pv;
    if (o == 1'b0) begin
      ia   = int'($signed(a));
      ib   = int'($signed(b));
      prod = ia * ib;
      pv   = prod;
      hi   = pv[2*NB-1:NB];
      lo   = pv[NB-1:0];
      dz   = 1'b0;
      lat  = NB + 1;
    end else if (b == '0) begin
      hi  = a;
      lo  = '1;
      dz  = 1'b1;
      lat = 1;
    end else begin
      lo  = NB'(int'(a) / int'(b));
      hi  = NB'(int'(a) % int'(b));
      dz  = 1'b0;
      lat = NB + 2;
    end
  endtask

  // Issue one op from IDLE; returns observed results, done latency (-1 on
  // timeout) and the done level one cycle after the pulse.
  task automatic run_op(input logic o, input logic [NB-1:0] a, input logic [NB-1:0] b,
                        input bit garble, input int lat_exp,
                        output logic [NB-1:0] hi, output logic [NB-1:0] lo,
                        output logic dz, output int lat, output logic done_after);
    lat = -1;
    done_after = 1'b0;
    hi = '0; lo = '0; dz = 1'b0;
    @(negedge clk);
    start = 1'b1; op = o; data_a = a; data_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= BUDGET; k++) begin
      @(posedge clk); #1;
      if (garble && k < lat_exp - 1) begin
        start  = 1'($urandom_range(0, 1));
        op     = 1'($urandom_range(0, 1));
        data_a = NB'($urandom);
        data_b = NB'($urandom);
      end else begin
        start = 1'b0;
      end
      if (done) begin
        lat = k;
        hi = result_hi; lo = result_lo; dz = div_by_zero;
        @(posedge clk); #1;
        done_after = done;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; op = 1'b0; data_a = '0; data_b = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({ready, busy, done, result_hi, result_lo, div_by_zero} !== {1'b1, 1'b0, 1'b0, NB'(0), NB'(0), 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b bsy=%b dn=%b hi=%h lo=%h dz=%b, want 1 0 0 0 0 0",
               ready, busy, done, result_hi, result_lo, div_by_zero);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_idle: got rdy=%b bsy=%b, want 1 0", ready, busy);
    end
  endtask

  typedef struct {
    logic          o;
    logic [NB-1:0] a, b, hi, lo;
    logic          dz;
    int            lat;
  } vec_t;

  task automatic test_directed();
    vec_t v[6];
    logic [NB-1:0] hi, lo;
    logic dz, da;
    int lat;
    v[0] = '{1'b0, 4'd3,  4'hE, 4'hF, 4'hA, 1'b0, 5};
    v[1] = '{1'b0, 4'h8,  4'h8, 4'h4, 4'h0, 1'b0, 5};
    v[2] = '{1'b0, 4'h7,  4'h8, 4'hC, 4'h8, 1'b0, 5};
    v[3] = '{1'b1, 4'd13, 4'd3, 4'd1, 4'd4, 1'b0, 6};
    v[4] = '{1'b1, 4'd15, 4'd1, 4'd0, 4'hF, 1'b0, 6};
    v[5] = '{1'b1, 4'd7,  4'd0, 4'd7, 4'hF, 1'b1, 1};
    foreach (v[i]) begin
      run_op(v[i].o, v[i].a, v[i].b, 1'b0, v[i].lat, hi, lo, dz, lat, da);
      n_checks++;
      if (lat !== v[i].lat) begin
        n_fail++;
        $display("FAIL directed_latency[%0d]: got %0d, want %0d", i, lat, v[i].lat);
      end
      n_checks++;
      if ({hi, lo, dz} !== {v[i].hi, v[i].lo, v[i].dz}) begin
        n_fail++;
        $display("FAIL directed_result[%0d]: got hi=%h lo=%h dz=%b, want hi=%h lo=%h dz=%b",
                 i, hi, lo, dz, v[i].hi, v[i].lo, v[i].dz);
      end
      n_checks++;
      if (da !== 1'b0) begin
        n_fail++;
        $display("FAIL directed_done_width[%0d]: done still %b one cycle later, want 0", i, da);
      end
    end
  endtask

  task automatic test_dbz_clear();
    logic [NB-1:0] hi, lo;
    logic dz, da;
    int lat;
    bit seen;
    run_op(1'b1, 4'd7, 4'd0, 1'b0, 1, hi, lo, dz, lat, da);
    @(negedge clk);
    start = 1'b1; op = 1'b1; data_a = 4'd6; data_b = 4'd2;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if ({div_by_zero, busy, ready} !== 3'b010) begin
      n_fail++;
      $display("FAIL dbz_clear_on_accept: got dz=%b bsy=%b rdy=%b, want 0 1 0", div_by_zero, busy, ready);
    end
    seen = 1'b0;
    for (int k = 1; k <= BUDGET && !seen; k++) begin
      @(posedge clk); #1;
      if (done) begin
        seen = 1'b1;
        n_checks++;
        if ({result_hi, result_lo, div_by_zero, 32'(k)} !== {4'd0, 4'd3, 1'b0, 32'(NB + 2)}) begin
          n_fail++;
          $display("FAIL dbz_next_div: got hi=%h lo=%h dz=%b cyc=%0d, want 0 3 0 %0d",
                   result_hi, result_lo, div_by_zero, k, NB + 2);
        end
      end
    end
    if (!seen) begin
      n_checks++; n_fail++;
      $display("FAIL dbz_next_div: timeout, got no done, want done");
    end
  endtask

  task automatic test_random();
    logic o, dz, edz, da;
    logic [NB-1:0] a, b, hi, lo, ehi, elo;
    int lat, elat;
    for (int i = 0; i < 60; i++) begin
      o = 1'($urandom_range(0, 1));
      a = NB'($urandom);
      b = ($urandom_range(0, 7) == 0) ? '0 : NB'($urandom);
      model(o, a, b, ehi, elo, edz, elat);
      run_op(o, a, b, 1'b1, elat, hi, lo, dz, lat, da);
      n_checks++;
      if (lat !== elat || {hi, lo, dz} !== {ehi, elo, edz} || da !== 1'b0) begin
        n_fail++;
        $display("FAIL random[%0d] op=%b a=%h b=%h: got hi=%h lo=%h dz=%b lat=%0d after=%b, want hi=%h lo=%h dz=%b lat=%0d after=0",
                 i, o, a, b, hi, lo, dz, lat, da, ehi, elo, edz, elat);
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [NB-1:0] hi, lo;
    logic dz, da;
    int lat;
    bit saw_done;
    saw_done = 1'b0;
    @(negedge clk);
    start = 1'b1; op = 1'b1; data_a = 4'd13; data_b = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    saw_done |= done;
    @(posedge clk); #1;
    saw_done |= done;
    start = 1'b1; op = 1'b0; data_a = 4'd2; data_b = 4'd2;
    @(posedge clk); #1;
    saw_done |= done;
    n_checks++;
    if (busy !== 1'b1 || ready !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_ignore_start: got bsy=%b rdy=%b, want 1 0", busy, ready);
    end
    start = 1'b0;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({ready, busy, done, result_hi, result_lo, div_by_zero} !== {1'b1, 1'b0, 1'b0, NB'(0), NB'(0), 1'b0}) begin
      n_fail++;
      $display("FAIL abort_async_reset: got rdy=%b bsy=%b dn=%b hi=%h lo=%h dz=%b, want 1 0 0 0 0 0",
               ready, busy, done, result_hi, result_lo, div_by_zero);
    end
    repeat (4) begin
      @(posedge clk); #1;
      saw_done |= done;
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      saw_done |= done;
    end
    n_checks++;
    if (saw_done !== 1'b0 || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_no_done: got done_seen=%b rdy=%b, want 0 1", saw_done, ready);
    end
    run_op(1'b0, 4'd2, 4'd2, 1'b0, NB + 1, hi, lo, dz, lat, da);
    n_checks++;
    if ({hi, lo, dz, 32'(lat)} !== {4'h0, 4'h4, 1'b0, 32'(NB + 1)}) begin
      n_fail++;
      $display("FAIL abort_then_mul: got hi=%h lo=%h dz=%b lat=%0d, want 0 4 0 %0d", hi, lo, dz, lat, NB + 1);
    end
  endtask

  task automatic test_back_to_back();
    bit done_at[13];
    bit rdy_at[13];
    logic [2*NB-1:0] prod_at[13];
    @(negedge clk);
    start = 1'b1; op = 1'b0; data_a = 4'd3; data_b = 4'd3;
    @(posedge clk); #1;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk); #1;
      done_at[k] = done;
      rdy_at[k]  = ready;
      prod_at[k] = {result_hi, result_lo};
      if (k == 11) start = 1'b0;
    end
    for (int k = 1; k <= 11; k++) begin
      n_checks++;
      if (done_at[k] !== (k == 5 || k == 11)) begin
        n_fail++;
        $display("FAIL b2b_done_cycle[%0d]: got %b, want %b", k, done_at[k], (k == 5 || k == 11));
      end
      if (k != 5 && k != 11) begin
        n_checks++;
        if (rdy_at[k] !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_ready[%0d]: got %b, want 0", k, rdy_at[k]);
        end
      end else begin
        n_checks++;
        if (prod_at[k] !== 8'h09) begin
          n_fail++;
          $display("FAIL b2b_product[%0d]: got %h, want 09", k, prod_at[k]);
        end
      end
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_no_third_op: got rdy=%b bsy=%b, want 1 0", ready, busy);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_dbz_clear();
    test_random();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
